// File: rtl/fir_pkg.sv
// Shared constants and types for the serial-MAC FIR filter.
// The numeric constants describe the default build (Q1.15 samples, 8 taps);
// modules that take N/TAPS parameters derive their own widths from those.
package fir_pkg;

    localparam int N     = 16;
    localparam int TAPS  = 8;
    localparam int ACC_W = 2 * N + $clog2(TAPS);

    localparam logic signed [N-1:0] SAT_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic signed [N-1:0] SAT_MIN = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fir_mac_unit.sv
// Single shared multiplier feeding a wide signed accumulator.
// The accumulator is 2N+clog2(TAPS) bits wide, so a full filter pass
// of worst-case products can never overflow it.
module fir_mac_unit #(
    parameter int N     = fir_pkg::N,
    parameter int ACC_W = fir_pkg::ACC_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    enable,
    input  logic signed [N-1:0]     sample,
    input  logic signed [N-1:0]     coef,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [2*N-1:0]   product;
    logic signed [ACC_W-1:0] product_ext;

    assign product     = sample * coef;
    assign product_ext = {{(ACC_W - 2 * N){product[2*N-1]}}, product};

    // Clear on a new sample, otherwise add one product per enabled cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (enable) begin
            acc <= acc + product_ext;
        end
    end

endmodule

// File: rtl/fir_mac_ctrl.sv
// Serial-MAC FIR controller: accepts one sample at a time, walks the
// circular delay line against the coefficient file over TAPS cycles using
// one shared MAC, then registers a saturated result with a one-cycle pulse.
module fir_mac_ctrl #(
    parameter int N    = fir_pkg::N,
    parameter int TAPS = fir_pkg::TAPS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [N-1:0]     data_in,
    input  logic                    coef_we,
    input  logic [$clog2(TAPS)-1:0] coef_addr,
    input  logic signed [N-1:0]     coef_data,
    output logic signed [N-1:0]     data_out,
    output logic                    out_valid,
    output logic                    busy
);

    import fir_pkg::*;

    localparam int PW = $clog2(TAPS);
    localparam int AW = 2 * N + PW;

    // Saturation limits sign-extended to accumulator width
    localparam logic signed [AW-1:0] CLAMP_HI = {{(AW - N + 1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [AW-1:0] CLAMP_LO = {{(AW - N + 1){1'b1}}, {(N-1){1'b0}}};

    state_t state;
    state_t next_state;

    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       tap_cnt;
    logic [PW-1:0]       rd_idx;
    logic signed [N-1:0] delay_line [TAPS];
    logic signed [N-1:0] coefs      [TAPS];

    logic                accept;
    logic                last_tap;
    logic                mac_enable;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] shifted;
    logic signed [N-1:0]  clamped;

    assign in_ready   = (state == IDLE);
    assign busy       = (state != IDLE);
    assign accept     = in_valid && (state == IDLE);
    assign mac_enable = (state == MAC);
    assign last_tap   = (tap_cnt == PW'(TAPS - 1));

    // Tap k pairs with the sample k steps older than the newest; the
    // power-of-two length makes the subtraction wrap modulo TAPS for free.
    assign rd_idx = wr_ptr - tap_cnt;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: IDLE waits for a sample, MAC runs TAPS products, DONE emits
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid) next_state = MAC;
            MAC:     if (last_tap) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Tap counter restarts on accept; write pointer advances once the last tap is done
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tap_cnt <= '0;
            wr_ptr  <= '0;
        end else if (accept) begin
            tap_cnt <= '0;
        end else if (state == MAC) begin
            tap_cnt <= tap_cnt + 1'b1;
            if (last_tap) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
        end
    end

    // Circular delay line: the accepted sample lands at the current write pointer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < TAPS; i++) begin
                delay_line[i] <= '0;
            end
        end else if (accept) begin
            delay_line[wr_ptr] <= data_in;
        end
    end

    // Coefficient file writable only while idle, so a pass never sees a changing tap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < TAPS; i++) begin
                coefs[i] <= '0;
            end
        end else if (coef_we && (state == IDLE)) begin
            coefs[coef_addr] <= coef_data;
        end
    end

    fir_mac_unit #(
        .N     (N),
        .ACC_W (AW)
    ) u_mac (
        .clk    (clk),
        .reset  (reset),
        .clear  (accept),
        .enable (mac_enable),
        .sample (delay_line[rd_idx]),
        .coef   (coefs[tap_cnt]),
        .acc    (acc)
    );

    // Rescale from Q2.30-style product sum back to Q1.15 and saturate
    always_comb begin
        shifted = acc >>> (N - 1);
        clamped = shifted[N-1:0];
        if (shifted > CLAMP_HI) begin
            clamped = CLAMP_HI[N-1:0];
        end else if (shifted < CLAMP_LO) begin
            clamped = CLAMP_LO[N-1:0];
        end
    end

    // Output register: result captured in DONE and held until the next pass
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= (state == DONE);
            if (state == DONE) begin
                data_out <= clamped;
            end
        end
    end

endmodule

// File: tb/tb_fir_mac_ctrl.sv
// Self-checking bench for fir_mac_ctrl against a direct-form FIR reference
// model (history array, newest first, with floor rescale and clamp).
module tb_fir_mac_ctrl;

    localparam int N    = 16;
    localparam int TAPS = 8;
    localparam int PW   = $clog2(TAPS);
    localparam int QMAX = (1 <<< (N - 1)) - 1;
    localparam int QMIN = -(1 <<< (N - 1));

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [N-1:0]  data_in = '0;
    logic                 coef_we = 1'b0;
    logic [PW-1:0]        coef_addr = '0;
    logic signed [N-1:0]  coef_data = '0;
    logic signed [N-1:0]  data_out;
    logic                 out_valid;
    logic                 busy;

    int checks    = 0;
    int failures  = 0;
    int sentCount = 0;

    int coefModel [TAPS];
    int histModel [TAPS];

    always #5 clk = ~clk;

    fir_mac_ctrl #(
        .N    (N),
        .TAPS (TAPS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .data_out  (data_out),
        .out_valid (out_valid),
        .busy      (busy)
    );

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic void modelReset();
        for (int k = 0; k < TAPS; k++) begin
            coefModel[k] = 0;
            histModel[k] = 0;
        end
    endfunction

    // y = clamp(floor(sum_k c[k]*x[n-k] / 2^(N-1)))
    function automatic int modelAccept(input int sample);
        longint sum;
        longint q;
        sum = 0;
        for (int k = TAPS - 1; k > 0; k--) begin
            histModel[k] = histModel[k-1];
        end
        histModel[0] = sample;
        for (int k = 0; k < TAPS; k++) begin
            sum += longint'(coefModel[k]) * longint'(histModel[k]);
        end
        q = sum >>> (N - 1);
        if (q > longint'(QMAX)) return QMAX;
        if (q < longint'(QMIN)) return QMIN;
        return int'(q);
    endfunction

    function automatic int randSample();
        logic signed [N-1:0] r;
        r = N'($urandom);
        if ($urandom_range(0, 3) == 0) begin
            return ($urandom_range(0, 1) == 1) ? QMAX : QMIN;
        end
        return int'(r);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resetCheck(input string tag);
        reset = 1'b1;
        in_valid = 1'b0;
        coef_we = 1'b0;
        #1;
        checkOutput({tag, "_data_out"}, int'(data_out), 0);
        checkOutput({tag, "_out_valid"}, int'(out_valid), 0);
        checkOutput({tag, "_in_ready"}, int'(in_ready), 1);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        tick();
        tick();
        reset = 1'b0;
        modelReset();
        sentCount = 0;
        tick();
    endtask

    task automatic writeCoef(input int addr, input int val);
        coef_we   = 1'b1;
        coef_addr = PW'(addr);
        coef_data = N'(val);
        tick();
        coef_we = 1'b0;
        coefModel[addr] = val;
    endtask

    // mode 0: plain sample; 1: coefficient write + in_valid pulse mid-MAC (both
    // must be ignored); 2: coefficient write on the accepting edge (must apply)
    task automatic applyStimulus(input int sample, input int mode, input int wAddr,
                                 input int wVal, output int result);
        int waitCnt;
        int expected;
        int lat;
        int okBusy;
        waitCnt = 0;
        while (!in_ready && waitCnt < 30) begin
            tick();
            waitCnt++;
        end
        checkOutput("ready_wait", int'(in_ready), 1);
        in_valid = 1'b1;
        data_in  = N'(sample);
        if (mode == 2) begin
            coef_we   = 1'b1;
            coef_addr = PW'(wAddr);
            coef_data = N'(wVal);
            coefModel[wAddr] = wVal;
        end
        expected = modelAccept(sample);
        sentCount++;
        tick();
        in_valid = 1'b0;
        coef_we  = 1'b0;
        data_in  = N'($urandom);
        lat = 0;
        okBusy = 1;
        while (!out_valid && lat < 20) begin
            if (in_ready || !busy) okBusy = 0;
            if (mode == 1 && lat == 2) begin
                coef_we   = 1'b1;
                coef_addr = PW'(wAddr);
                coef_data = N'(wVal);
                in_valid  = 1'b1;
            end
            tick();
            lat++;
            coef_we  = 1'b0;
            in_valid = 1'b0;
        end
        checkOutput("latency", lat, TAPS + 1);
        checkOutput("busy_during_mac", okBusy, 1);
        checkOutput("data_out", int'(data_out), expected);
        result = int'(data_out);
        tick();
        checkOutput("out_valid_pulse", int'(out_valid), 0);
        checkOutput("data_out_hold", int'(data_out), expected);
    endtask

    task automatic impulseRun(input string tag);
        int res;
        for (int k = 0; k < TAPS; k++) writeCoef(k, 1000 * (k + 1));
        for (int i = 0; i <= TAPS; i++) begin
            applyStimulus((i == 0) ? 16384 : 0, 0, 0, 0, res);
            checkOutput(tag, res, (i < TAPS) ? 500 * (i + 1) : 0);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin : main
        int res;
        int acceptEdge[$];
        int expQ[$];
        int lastAccept;
        int accepts;
        int outs;
        int okReady;
        int sawOut;

        modelReset();
        #2;
        resetCheck("reset_initial");

        // impulse response
        impulseRun("impulse");

        // saturation in both directions
        for (int k = 0; k < TAPS; k++) writeCoef(k, QMAX);
        for (int i = 0; i < TAPS; i++) applyStimulus(QMAX, 0, 0, 0, res);
        checkOutput("sat_pos", res, QMAX);
        for (int i = 0; i < TAPS; i++) applyStimulus(QMIN, 0, 0, 0, res);
        checkOutput("sat_neg", res, QMIN);

        // random coefficients and samples against the model
        for (int k = 0; k < TAPS; k++) writeCoef(k, int'($urandom_range(0, 16383)) - 8192);
        for (int i = 0; i < 12; i++) applyStimulus(randSample(), 0, 0, 0, res);

        // continuous in_valid: fixed accept cadence and latency, data_in ignored while busy
        lastAccept = -1;
        accepts = 0;
        outs = 0;
        okReady = 1;
        for (int c = 0; c < 56; c++) begin
            if (out_valid) begin
                if (acceptEdge.size() == 0) begin
                    checkOutput("hs_unexpected_out", 1, 0);
                end else begin
                    checkOutput("hs_out_delay", c - acceptEdge.pop_front(), TAPS + 1);
                    checkOutput("hs_data", int'(data_out), expQ.pop_front());
                    outs++;
                end
            end
            if (in_ready == busy) okReady = 0;
            in_valid = (c < 45);
            data_in  = N'($urandom);
            if (in_valid && in_ready) begin
                if (lastAccept >= 0) checkOutput("hs_spacing", c + 1 - lastAccept, TAPS + 2);
                lastAccept = c + 1;
                acceptEdge.push_back(c + 1);
                expQ.push_back(modelAccept(int'(data_in)));
                sentCount++;
                accepts++;
            end
            tick();
        end
        in_valid = 1'b0;
        checkOutput("hs_ready_vs_busy", okReady, 1);
        checkOutput("hs_accepts", accepts, 5);
        checkOutput("hs_outputs", outs, 5);

        // coefficient write during MAC ignored; write on the accept edge applies
        for (int k = 0; k < TAPS; k++) writeCoef(k, int'($urandom_range(0, 4000)) - 2000);
        applyStimulus(20000, 1, 0, 30000, res);
        applyStimulus(20000, 2, 0, -15000, res);

        // reset during MAC at tap_cnt=3: aborted, then clean impulse response
        if (sentCount % TAPS == 0) applyStimulus(randSample(), 0, 0, 0, res);
        while (!in_ready) tick();
        in_valid = 1'b1;
        data_in  = N'(16384);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        resetCheck("reset_mid_mac");
        sawOut = 0;
        for (int c = 0; c < 12; c++) begin
            if (out_valid) sawOut = 1;
            tick();
        end
        checkOutput("abort_no_out_valid", sawOut, 0);
        impulseRun("impulse_after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
